// File: rtl/cpu_sequencer_ext_pkg.sv
// Shared types and encodings for the extended CPU control sequencer.
package seq_pkg;

    typedef enum logic [3:0] {
        S_FETCH          = 4'd0,
        S_FETCH_WAIT     = 4'd1,
        S_DECODE         = 4'd2,
        S_LOAD_MEM       = 4'd3,
        S_LOAD_MEM_WAIT  = 4'd4,
        S_STORE_MEM      = 4'd5,
        S_STORE_MEM_WAIT = 4'd6,
        S_ALU_EXEC       = 4'd7,
        S_UPDATE_PC      = 4'd8,
        S_IRQ_ENTRY      = 4'd9,
        S_HALT           = 4'd10,
        S_FAULT          = 4'd11
    } seq_state_t;

    localparam logic [1:0] INST_F = 2'b00;
    localparam logic [1:0] INST_J = 2'b01;
    localparam logic [1:0] INST_R = 2'b10;
    localparam logic [1:0] INST_I = 2'b11;

    localparam logic [1:0] IMM_LD  = 2'b00;
    localparam logic [1:0] IMM_ST  = 2'b01;
    localparam logic [1:0] IMM_LDI = 2'b10;

    localparam logic [1:0] FAULT_NONE      = 2'b00;
    localparam logic [1:0] FAULT_FETCH_TO  = 2'b01;
    localparam logic [1:0] FAULT_LOAD_TO   = 2'b10;
    localparam logic [1:0] FAULT_STORE_ILL = 2'b11;

    // States whose dwell time is measured by the shared timer.
    function automatic logic is_timed(input seq_state_t s);
        return (s == S_FETCH_WAIT) || (s == S_LOAD_MEM_WAIT) ||
               (s == S_STORE_MEM_WAIT) || (s == S_ALU_EXEC);
    endfunction

endpackage

// File: rtl/cpu_sequencer_ext_wait_timer.sv
// Loadable down-counter; expire_o is high while the count sits at zero.
module seq_wait_timer #(
    parameter int W = 6
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/cpu_sequencer_ext.sv
// Multi-cycle fetch/decode/execute sequencer with wait timeout, multi-cycle ALU,
// interrupt entry, debug halt/step and a retired-instruction counter.
module cpu_sequencer_ext
    import seq_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 64,
    parameter int ALU_LAT      = 1,
    parameter int IRQ_EN       = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic             mem_busy_in,
    input  logic             inst_fetch_done_in,
    input  logic             data_read_done_in,
    input  logic [1:0]       inst_type_in,
    input  logic [1:0]       imm_type_in,
    input  logic             irq_in,
    input  logic             halt_req_in,
    input  logic             step_in,
    input  logic             fault_clear_in,
    output logic [3:0]       seq_state_out,
    output logic             retire_out,
    output logic             halted_out,
    output logic             fault_out,
    output logic [1:0]       fault_code_out,
    output logic [CNT_W-1:0] retire_count_out
);

    localparam int  TMAX  = (WAIT_TIMEOUT > ALU_LAT) ? WAIT_TIMEOUT : ALU_LAT;
    localparam int  TW    = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam bit  TO_EN = (WAIT_TIMEOUT != 0);
    localparam logic [TW-1:0] WAIT_LD = TW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);
    localparam logic [TW-1:0] ALU_LD  = TW'((ALU_LAT > 0) ? ALU_LAT - 1 : 0);

    seq_state_t       state_q, state_d;
    logic [1:0]       fcode_q, fcode_d;
    logic [CNT_W-1:0] rcnt_q;
    logic             tmr_load, tmr_exp;
    logic [TW-1:0]    tmr_val;

    // Timer restarts only on entry, so a self-looping wait keeps counting down.
    assign tmr_load = is_timed(state_d) && (state_d != state_q);
    assign tmr_val  = (state_d == S_ALU_EXEC) ? ALU_LD : WAIT_LD;

    seq_wait_timer #(.W(TW)) u_timer (
        .clk_i      (clk_in),
        .reset_n_i  (reset_n_in),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_exp)
    );

    always_comb begin
        state_d = state_q;
        fcode_d = fcode_q;
        case (state_q)
            S_FETCH: state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (inst_fetch_done_in) begin
                    state_d = S_DECODE;
                end else if (TO_EN && tmr_exp) begin
                    state_d = S_FAULT;
                    fcode_d = FAULT_FETCH_TO;
                end
            end
            S_DECODE: begin
                case (inst_type_in)
                    INST_F, INST_J: state_d = S_UPDATE_PC;
                    INST_R:         state_d = S_ALU_EXEC;
                    default: begin
                        case (imm_type_in)
                            IMM_LD:  state_d = S_LOAD_MEM;
                            IMM_ST:  state_d = S_STORE_MEM;
                            IMM_LDI: state_d = S_UPDATE_PC;
                            default: begin
                                state_d = S_FAULT;
                                fcode_d = FAULT_STORE_ILL;
                            end
                        endcase
                    end
                endcase
            end
            S_LOAD_MEM: state_d = S_LOAD_MEM_WAIT;
            S_LOAD_MEM_WAIT: begin
                if (data_read_done_in) begin
                    state_d = S_UPDATE_PC;
                end else if (TO_EN && tmr_exp) begin
                    state_d = S_FAULT;
                    fcode_d = FAULT_LOAD_TO;
                end
            end
            S_STORE_MEM: state_d = S_STORE_MEM_WAIT;
            S_STORE_MEM_WAIT: begin
                if (!mem_busy_in) begin
                    state_d = S_UPDATE_PC;
                end else if (TO_EN && tmr_exp) begin
                    state_d = S_FAULT;
                    fcode_d = FAULT_STORE_ILL;
                end
            end
            S_ALU_EXEC: if (tmr_exp) state_d = S_UPDATE_PC;
            S_UPDATE_PC: begin
                if ((IRQ_EN != 0) && irq_in) state_d = S_IRQ_ENTRY;
                else if (halt_req_in)        state_d = S_HALT;
                else                         state_d = S_FETCH;
            end
            S_IRQ_ENTRY: state_d = S_FETCH;
            S_HALT: if (!halt_req_in || step_in) state_d = S_FETCH;
            S_FAULT: begin
                if (fault_clear_in) begin
                    state_d = S_FETCH;
                    fcode_d = FAULT_NONE;
                end
            end
            default: begin
                state_d = S_FETCH;
                fcode_d = FAULT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state_q <= S_FETCH;
            fcode_q <= FAULT_NONE;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcode_q <= fcode_d;
            if (state_q == S_UPDATE_PC) rcnt_q <= rcnt_q + 1'b1;
        end
    end

    assign seq_state_out    = state_q;
    assign retire_out       = (state_q == S_UPDATE_PC);
    assign halted_out       = (state_q == S_HALT);
    assign fault_out        = (state_q == S_FAULT);
    assign fault_code_out   = fcode_q;
    assign retire_count_out = rcnt_q;

endmodule
